fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Purpose : pulls one word from an upstream FIFO and transmits it as an
//           8N1-style UART frame (start, DATA_WIDTH bits LSB first, stop).
// Latency : fifo_rd one cycle after the start edge, tx start bit RD_LATENCY
//           cycles after fifo_rd, frame lasts (DATA_WIDTH+2)*CLKS_PER_BIT.
// Backpressure: a new word is read only from IDLE with tx_en=1 and
//           fifo_empty=0; a running frame always completes unless reset.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   tx_en      permits starting a new frame (looked at only in IDLE)
//   fifo_empty upstream FIFO empty flag
//   fifo_dout  upstream FIFO read data, valid RD_LATENCY cycles after fifo_rd
//   fifo_rd    registered single-cycle read strobe
//   tx         registered serial line, idles high
//   busy       registered, high whenever the FSM is not in IDLE
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int RD_LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  // The latency counter only has to reach RD_LATENCY-1.
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_nxt;
  logic [DATA_WIDTH-1:0] shreg, sh_nxt;
  logic                  rd_nxt;
  logic                  tx_nxt;
  logic                  busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      shreg    <= '0;
      fifo_rd  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      lat_cnt  <= lat_nxt;
      shreg    <= sh_nxt;
      fifo_rd  <= rd_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    lat_nxt   = lat_cnt;
    sh_nxt    = shreg;
    rd_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_nxt = WAIT;
          rd_nxt    = 1'b1;
          lat_nxt   = '0;
        end
      end

      // The first WAIT cycle is the one with fifo_rd high; fifo_empty is
      // deliberately not looked at here because it lags the read.
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          sh_nxt    = fifo_dout;
          state_nxt = START;
          baud_nxt  = '0;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end

      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      // shreg[0] is always the bit on the line; shift at each bit boundary.
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt = '0;
          sh_nxt   = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // tx and busy are registered from the next-state values so the line
  // changes on the same edge as the state.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule
